// File: rtl/bus_master.sv
// Single-word bus master: arbitrates for the bus, runs one read or write per command
// with asynchronous dtack/berr handshake and a WAIT timeout, then releases or chains.
module bus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [22:0] cmd_addr,
  input  logic [1:0]  cmd_be,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        br,
  input  logic        bg,
  input  logic        bgack_in,
  output logic        bgack,
  input  logic        as_in,
  input  logic        dtack,
  input  logic        berr,
  input  logic [15:0] data_in,
  output logic        bus_oe,
  output logic [22:0] addr,
  output logic        as,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  output logic [15:0] data_out,
  output logic        data_oe
);

  typedef enum logic [3:0] {IDLE, REQ, OWN, ASTB, DSTB, WAIT, END, NEG, REL} state_t;

  state_t      state, state_n;
  logic        dtack_m, dtack_s, berr_m, berr_s;
  logic [7:0]  cnt;
  logic [1:0]  be_q, be_d, be_eff;
  logic        accept, timed_out;

  logic        br_d, bgack_d, bus_oe_d, cmd_ready_d, rsp_valid_d, rsp_err_d;
  logic        as_d, uds_d, lds_d, rw_d, data_oe_d;
  logic [22:0] addr_d;
  logic [15:0] data_out_d, rsp_rdata_d;

  assign be_eff    = (cmd_be == 2'b00) ? 2'b11 : cmd_be;
  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (cnt == 8'(TIMEOUT - 1));

  // Synchronizers idle at the negated (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
      berr_m  <= 1'b1;
      berr_s  <= 1'b1;
    end else begin
      dtack_m <= dtack;
      dtack_s <= dtack_m;
      berr_m  <= berr;
      berr_s  <= berr_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      be_q      <= '0;
      br        <= 1'b1;
      bgack     <= 1'b1;
      bus_oe    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      as        <= 1'b1;
      uds       <= 1'b1;
      lds       <= 1'b1;
      rw        <= 1'b1;
      addr      <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (state == WAIT) ? cnt + 8'd1 : '0;
      be_q      <= be_d;
      br        <= br_d;
      bgack     <= bgack_d;
      bus_oe    <= bus_oe_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      as        <= as_d;
      uds       <= uds_d;
      lds       <= lds_d;
      rw        <= rw_d;
      addr      <= addr_d;
      data_out  <= data_out_d;
      data_oe   <= data_oe_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_valid) state_n = REQ;
      REQ:  if (!bg && as_in && dtack_s && bgack_in) state_n = OWN;
      OWN:  state_n = accept ? ASTB : (cmd_valid ? OWN : REL);
      ASTB: state_n = rw ? WAIT : DSTB;
      DSTB: state_n = WAIT;
      WAIT: if (!berr_s || !dtack_s || timed_out) state_n = END;
      END:  state_n = NEG;
      NEG:  if (dtack_s && berr_s) state_n = cmd_valid ? OWN : REL;
      REL:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they appear on the same edge.
  always_comb begin
    br_d        = (state_n != REQ);
    bus_oe_d    = state_n inside {OWN, ASTB, DSTB, WAIT, END, NEG};
    bgack_d     = !bus_oe_d;
    cmd_ready_d = (state_n == OWN);
    rsp_valid_d = (state_n == END);
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    as_d        = as;
    uds_d       = uds;
    lds_d       = lds;
    rw_d        = rw;
    addr_d      = addr;
    data_out_d  = data_out;
    data_oe_d   = data_oe;
    be_d        = be_q;
    case (state)
      REQ, NEG: if (state_n == OWN) begin
        as_d  = 1'b1;
        uds_d = 1'b1;
        lds_d = 1'b1;
        rw_d  = 1'b1;
      end
      OWN: if (accept) begin
        addr_d     = cmd_addr;
        rw_d       = !cmd_write;
        data_out_d = cmd_wdata;
        data_oe_d  = cmd_write;
        be_d       = be_eff;
        as_d       = 1'b0;
        if (!cmd_write) begin
          uds_d = !be_eff[1];
          lds_d = !be_eff[0];
        end
      end
      ASTB: if (!rw) begin
        uds_d = !be_q[1];
        lds_d = !be_q[0];
      end
      WAIT: if (state_n == END) begin
        as_d        = 1'b1;
        uds_d       = 1'b1;
        lds_d       = 1'b1;
        data_oe_d   = 1'b0;
        rsp_err_d   = !berr_s || dtack_s;
        rsp_rdata_d = (berr_s && !dtack_s && rw) ? data_in : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master.sv
// Randomized self-checking bench for bus_master with a behavioural bus-slave model.
module tb_bus_master;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_write;
  logic [22:0] cmd_addr, addr;
  logic [1:0]  cmd_be;
  logic [15:0] cmd_wdata, rsp_rdata, data_in, data_out;
  logic        rsp_valid, rsp_err, br, bg, bgack_in, bgack, as_in, dtack, berr;
  logic        bus_oe, as, uds, lds, rw, data_oe;

  int n_vec = 0;
  int n_err = 0;
  logic [22:0] last_addr;
  logic        last_rw;

  bus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .br(br), .bg(bg), .bgack_in(bgack_in), .bgack(bgack), .as_in(as_in),
    .dtack(dtack), .berr(berr), .data_in(data_in), .bus_oe(bus_oe), .addr(addr),
    .as(as), .uds(uds), .lds(lds), .rw(rw), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({br, bgack, as, uds, lds, rw, bus_oe, data_oe, cmd_ready, rsp_valid, rsp_err} !== 11'b11111100000) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want %b",
               {br, bgack, as, uds, lds, rw, bus_oe, data_oe, cmd_ready, rsp_valid, rsp_err}, 11'b11111100000);
    end
    n_vec++;
    if (addr !== 23'd0) begin n_err++; $display("FAIL reset_addr: got %h want 0", addr); end
    n_vec++;
    if (data_out !== 16'd0) begin n_err++; $display("FAIL reset_dout: got %h want 0", data_out); end
    n_vec++;
    if (rsp_rdata !== 16'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    reset = 1'b0;
  endtask

  // kind: 0 dtack, 1 berr, 2 berr+dtack together, 3 no response (timeout)
  task automatic run_txn(input logic w, input logic [22:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input int kind, input int dly,
                         input logic [15:0] rd, input bit b2b, input bit next_valid);
    logic [1:0]  bee;
    logic [15:0] exp_rd;
    bit got;
    int k, exp_lat;
    bee     = (be == 2'b00) ? 2'b11 : be;
    exp_rd  = (kind == 0 && !w) ? rd : 16'd0;
    exp_lat = (kind == 3) ? TO + 1 + int'(w) : dly + 3;
    cmd_write = w; cmd_addr = a; cmd_be = be; cmd_wdata = wd; cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (b2b) begin
        n_vec++;
        if ({bgack, br} !== 2'b01) begin
          n_err++; $display("FAIL b2b_hold: bgack,br got %b want 01", {bgack, br});
        end
      end
      got = cmd_ready;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL accept: cmd_ready got 0 want 1 within 40 cycles"); end
    @(negedge clk);
    cmd_valid = next_valid;
    last_addr = a; last_rw = !w;
    n_vec++;
    if ({as, rw, data_oe} !== {1'b0, !w, w}) begin
      n_err++; $display("FAIL astb: as,rw,data_oe got %b want %b", {as, rw, data_oe}, {1'b0, !w, w});
    end
    n_vec++;
    if (addr !== a) begin n_err++; $display("FAIL addr: got %h want %h", addr, a); end
    n_vec++;
    if ({uds, lds} !== (w ? 2'b11 : ~bee)) begin
      n_err++; $display("FAIL strobe_astb: uds,lds got %b want %b", {uds, lds}, (w ? 2'b11 : ~bee));
    end
    if (w) begin
      n_vec++;
      if (data_out !== wd) begin n_err++; $display("FAIL wdata: got %h want %h", data_out, wd); end
    end
    k = 0;
    got = 1'b0;
    while (k < 60 && !got) begin
      if (k == dly) begin
        data_in = rd;
        dtack = !(kind == 0 || kind == 2);
        berr  = !(kind == 1 || kind == 2);
      end
      @(negedge clk);
      k++;
      got = rsp_valid;
      if (w && k == 1) begin
        n_vec++;
        if ({as, uds, lds} !== {1'b0, ~bee}) begin
          n_err++; $display("FAIL strobe_dstb: as,uds,lds got %b want %b", {as, uds, lds}, {1'b0, ~bee});
        end
      end
      n_vec++;
      if ({bgack, br, bus_oe} !== 3'b011) begin
        n_err++; $display("FAIL own_hold: bgack,br,bus_oe got %b want 011", {bgack, br, bus_oe});
      end
    end
    n_vec++;
    if (k !== exp_lat) begin n_err++; $display("FAIL latency: got %0d want %0d cycles", k, exp_lat); end
    n_vec++;
    if (rsp_err !== (kind != 0)) begin
      n_err++; $display("FAIL rsp_err: got %b want %b", rsp_err, (kind != 0));
    end
    n_vec++;
    if (rsp_rdata !== exp_rd) begin n_err++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, exp_rd); end
    n_vec++;
    if ({as, uds, lds, data_oe} !== 4'b1110) begin
      n_err++; $display("FAIL end_neg: as,uds,lds,data_oe got %b want 1110", {as, uds, lds, data_oe});
    end
    dtack = 1'b1; berr = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic end_session();
    bit rel = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !rel; i++) begin
      @(negedge clk);
      rel = bgack;
    end
    n_vec++;
    if ({rel, bus_oe, br} !== 3'b101) begin
      n_err++; $display("FAIL release: bgack,bus_oe,br got %b want 101", {rel, bus_oe, br});
    end
    n_vec++;
    if ({addr, rw} !== {last_addr, last_rw}) begin
      n_err++; $display("FAIL idle_hold: addr,rw got %h/%b want %h/%b", addr, rw, last_addr, last_rw);
    end
  endtask

  task automatic test_arbitration();
    cmd_write = 1'b0; cmd_addr = 23'h000100; cmd_be = 2'b11; cmd_wdata = '0;
    bg = 1'b1; cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n_vec++;
      if ({br, bgack, bus_oe} !== 3'b010) begin
        n_err++; $display("FAIL arb_wait: br,bgack,bus_oe got %b want 010", {br, bgack, bus_oe});
      end
    end
    bgack_in = 1'b0; bg = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if (bgack !== 1'b1) begin n_err++; $display("FAIL arb_other: bgack got %b want 1", bgack); end
    end
    bgack_in = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bgack, br} !== 2'b01) begin
      n_err++; $display("FAIL arb_grant: bgack,br got %b want 01", {bgack, br});
    end
    last_addr = addr; last_rw = rw;
    end_session();
  endtask

  task automatic test_word_read();
    run_txn(1'b0, 23'h040000, 2'b11, 16'h0000, 0, 3, 16'hBEEF, 1'b0, 1'b0);
    end_session();
  endtask

  task automatic test_byte_write();
    run_txn(1'b1, 23'h012345, 2'b01, 16'h00A5, 0, 2, 16'h0000, 1'b0, 1'b0);
    end_session();
  endtask

  task automatic test_errors();
    run_txn(1'b0, 23'h000200, 2'b10, 16'h0000, 1, 1, 16'h1234, 1'b0, 1'b1);
    run_txn(1'b0, 23'h000202, 2'b00, 16'h0000, 2, 4, 16'h5678, 1'b1, 1'b1);
    run_txn(1'b0, 23'h000204, 2'b11, 16'h0000, 3, 0, 16'h9ABC, 1'b1, 1'b0);
    end_session();
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 23'h001000, 2'b11, 16'h0000, 0, 1, 16'hCAFE, 1'b0, 1'b1);
    run_txn(1'b0, 23'h001001, 2'b11, 16'h0000, 0, 5, 16'hF00D, 1'b1, 1'b0);
    end_session();
  endtask

  task automatic test_random();
    bit held = 1'b0;
    bit nxt;
    int r, kind;
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : 3;
      nxt = (t != 23) && ($urandom_range(0, 1) == 1);
      run_txn(1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom), kind,
              $urandom_range(0, 8), 16'($urandom), held, nxt);
      if (!nxt) end_session();
      held = nxt;
    end
  endtask

  task automatic test_reset_wait();
    bit got = 1'b0;
    cmd_write = 1'b0; cmd_addr = 23'h070707; cmd_be = 2'b11; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus_oe, as, bgack, br, rsp_valid, cmd_ready} !== 6'b011100) begin
      n_err++; $display("FAIL reset_wait: bus_oe,as,bgack,br,rsp_valid,cmd_ready got %b want 011100",
                        {bus_oe, as, bgack, br, rsp_valid, cmd_ready});
    end
    reset = 1'b0;
    repeat (TO + 4) begin
      @(negedge clk);
      n_vec++;
      if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_drop: rsp_valid got 1 want 0"); end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
    bg = 1'b1; bgack_in = 1'b1; as_in = 1'b1; dtack = 1'b1; berr = 1'b1; data_in = '0;
    last_addr = '0; last_rw = 1'b1;
    test_reset();
    test_arbitration();
    test_word_read();
    test_byte_write();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 TIMEOUT, 255, cycles in WAIT before a cycle is ended as an error; legal range 1..255.
REQ-002 clk  in  1  system clock; the one clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request; held until accepted.
REQ-005 cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  23  word address A23..A1.
REQ-008 cmd_be  in  2  byte enables; bit1 drives uds, bit0 drives lds; 2'b00 is treated as 2'b11.
REQ-009 cmd_wdata  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle pulse; cycle completed.
REQ-011 rsp_rdata  out  16  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  qualified by rsp_valid; 1 = bus error or timeout.
REQ-013 br  out  1  bus request, active low.
REQ-014 bg  in  1  bus grant, active low.
REQ-015 bgack_in  in  1  bus grant acknowledge from other masters, active low.
REQ-016 bgack  out  1  this block owns the bus, active low.
REQ-017 as_in  in  1  bus address strobe as observed on the bus, active low.
REQ-018 dtack  in  1  asynchronous, active low.
REQ-019 berr  in  1  asynchronous, active low.
REQ-020 data_in  in  16  bus data.
REQ-021 bus_oe  out  1  enables the addr/as/uds/lds/rw drivers.
REQ-022 addr  out  23  A23..A1.
REQ-023 as  out  1  address strobe, active low.
REQ-024 uds  out  1  upper data strobe, active low.
REQ-025 lds  out  1  lower data strobe, active low.
REQ-026 rw  out  1  1 = read, 0 = write.
REQ-027 data_out  out  16  write data.
REQ-028 data_oe  out  1  enables the data drivers.

Function
REQ-029 Two-flop synchronizers: dtack and berr pass through them; the FSM uses only dtack_s and berr_s. All outputs are registered.
REQ-030 States: IDLE, REQ, OWN, ASTB, DSTB, WAIT, END, NEG, REL.
REQ-031 IDLE: on cmd_valid -> REQ; br=0 from the next edge.
REQ-032 REQ: when bg=0, as_in=1, dtack_s=1 and bgack_in=1 are all sampled in the same cycle -> OWN; bgack=0 and br=1 from the next edge.
REQ-033 OWN: bus_oe=1; as, uds and lds negated; rw=1; cmd_ready=1 (in OWN only).
- On accept: latch addr, rw=~cmd_write, data_out=cmd_wdata, data_oe=cmd_write -> ASTB.
- If cmd_valid=0: -> REL.
REQ-034 ASTB: as=0.
- Read: uds/lds asserted on the same edge per be -> WAIT.
- Write: -> DSTB; strobes asserted one edge later -> WAIT.
REQ-035 WAIT: an 8-bit counter clears on entry and increments each cycle.
- berr_s=0 -> END with err=1; berr has priority over a same-cycle dtack_s=0.
- Else dtack_s=0 -> END; capture data_in (read only), err=0.
- Else counter=TIMEOUT-1 -> END with err=1 (TIMEOUT WAIT cycles).
REQ-036 END (one cycle): as, uds and lds negated and data_oe=0 on entry; rsp_valid=1 for this cycle only -> NEG.
REQ-037 NEG: wait for dtack_s=1 and berr_s=1.
- cmd_valid=1 -> OWN; bgack stays 0 and br stays 1 (back-to-back transfers).
- Else -> REL.
REQ-038 REL (one cycle): bus_oe=0, bgack=1 -> IDLE.
REQ-039 No bus output changes while bus_oe=0 except br and bgack; addr and rw hold their last values.

Reset
REQ-040 Reset values: br=1, bgack=1, as=1, uds=1, lds=1, rw=1, bus_oe=0, data_oe=0, addr=0, data_out=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0; state IDLE; counter and synchronizers cleared.
REQ-041 Reset asserted in any state, including mid-cycle, produces the reset values on the next edge and drops any pending response.

Verification
REQ-042 Arbitration: cmd_valid=1 with bg=1 for 10 cycles -> br=0, bgack=1, bus_oe=0 throughout; then bg=0 -> bgack=0 and br=1 one edge later; with bgack_in=0 held, no grant is taken.
REQ-043 Word read: addr 0x040000, be=11, dtack asserted 3 cycles after as, data_in=0xBEEF -> uds=lds=0 on the same edge as as=0; rsp_valid one cycle; rsp_rdata=0xBEEF; rsp_err=0.
REQ-044 Byte write: be=01, wdata=0x00A5 -> rw=0, data_oe=1, lds=0 one cycle after as=0, uds stays 1; strobes negated in END.
REQ-045 Errors: berr alone -> rsp_err=1; berr and dtack in the same cycle -> rsp_err=1; TIMEOUT=16 with no response -> rsp_valid after 16 WAIT cycles, rsp_err=1, as=1.
REQ-046 Back-to-back: two queued reads -> bgack stays 0 across both with no br pulse; bus_oe=0 and bgack=1 only after the second NEG.
REQ-047 Reset during WAIT -> next edge bus_oe=0, as=1, bgack=1, br=1, and no rsp_valid.
